// File: rtl/sar_pkg.sv
// Shared types and helpers for the multi-channel SAR scan controller:
// FSM state encoding, channel-select width and mask scanning.
package sar_pkg;

  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, STORE} state_t;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Index of the lowest set bit at or above 'from'; 16 when there is none.
  function automatic logic [4:0] lowest_set_from(input logic [15:0] mask,
                                                 input logic [4:0]  from);
    logic [4:0] r;
    r = 5'h10;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i] && (5'(i) >= from)) r = 5'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/sar_bit_engine.sv
// Single successive-approximation conversion: MSB-first trial register
// driven straight onto the DAC, with a one-cycle done pulse after the LSB.
module sar_bit_engine #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic             cmp_in,
  output logic             done,
  output logic [WIDTH-1:0] code
);

  localparam int BW = $clog2(WIDTH);

  logic [BW-1:0] bit_idx;
  logic          active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code    <= '0;
      bit_idx <= '0;
      active  <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        code   <= '0;
        active <= 1'b0;
      end else if (start) begin
        code              <= '0;
        code[WIDTH-1]     <= 1'b1;
        bit_idx           <= BW'(WIDTH - 1);
        active            <= 1'b1;
      end else if (active) begin
        // Decide the current bit, then raise the next lower trial bit.
        code[bit_idx] <= cmp_in;
        if (bit_idx != '0) begin
          code[bit_idx - BW'(1)] <= 1'b1;
          bit_idx                <= bit_idx - BW'(1);
        end else begin
          active <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sar_scan_ctrl.sv
// Multi-channel SAR scan sequencer with a one-deep valid/ready result register.
// Define SAR_AVG_EN to average 2^AVG_LOG2 conversions per channel.
module sar_scan_ctrl
  import sar_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int NUM_CH        = 4,
  parameter int SAMPLE_CYCLES = 2,
  parameter int AVG_LOG2      = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        cont,
  input  logic [NUM_CH-1:0]           ch_mask,
  input  logic                        cmp_in,
  output logic [WIDTH-1:0]            dac_code,
  output logic                        sample_en,
  output logic [ch_w(NUM_CH)-1:0]     ch_sel,
  output logic                        busy,
  output logic [WIDTH-1:0]            result,
  output logic [ch_w(NUM_CH)-1:0]     result_ch,
  output logic                        result_valid,
  input  logic                        result_ready
);

  localparam int CH_W = ch_w(NUM_CH);
  localparam int SC_W = $clog2(SAMPLE_CYCLES + 1);

  state_t            state;
  logic [NUM_CH-1:0] mask_q;
  logic [SC_W-1:0]   samp_cnt;
  logic              eng_start, eng_clr, eng_done;
  logic [WIDTH-1:0]  eng_code, store_code;
  logic              store_ok, more_reps;
  logic [15:0]       mask_pad, live_pad;
  logic [4:0]        nxt_ch, first_ch;

  always_comb begin
    mask_pad = '0;
    mask_pad[NUM_CH-1:0] = mask_q;
    live_pad = '0;
    live_pad[NUM_CH-1:0] = ch_mask;
    nxt_ch   = lowest_set_from(mask_pad, 5'(ch_sel) + 5'd1);
    first_ch = lowest_set_from(live_pad, 5'd0);
  end

  assign eng_start = (state == SAMPLE) && (samp_cnt == SC_W'(1));
  assign store_ok  = (state == STORE) && (!result_valid || result_ready);
  // The trial register is cleared whenever a new sample phase begins or the scan ends.
  assign eng_clr   = (state == IDLE) || store_ok ||
                     ((state == CONVERT) && eng_done && more_reps);
  assign dac_code  = eng_code;

  sar_bit_engine #(.WIDTH(WIDTH)) u_engine (
    .clk    (clk),
    .rst    (rst),
    .start  (eng_start),
    .clear  (eng_clr),
    .cmp_in (cmp_in),
    .done   (eng_done),
    .code   (eng_code)
  );

`ifdef SAR_AVG_EN
  localparam int N_REP = 1 << AVG_LOG2;

  logic [WIDTH+AVG_LOG2-1:0] acc;
  logic [AVG_LOG2:0]         rep;

  assign more_reps  = (int'(rep) != N_REP - 1);
  assign store_code = acc[WIDTH+AVG_LOG2-1:AVG_LOG2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      rep <= '0;
    end else if ((state == CONVERT) && eng_done) begin
      acc <= acc + {{AVG_LOG2{1'b0}}, eng_code};
      rep <= more_reps ? rep + {{AVG_LOG2{1'b0}}, 1'b1} : '0;
    end else if (store_ok) begin
      acc <= '0;
    end
  end
`else
  assign more_reps  = 1'b0;
  assign store_code = eng_code;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      mask_q       <= '0;
      ch_sel       <= '0;
      samp_cnt     <= '0;
      sample_en    <= 1'b0;
      busy         <= 1'b0;
      result       <= '0;
      result_ch    <= '0;
      result_valid <= 1'b0;
    end else begin
      if (result_valid && result_ready) result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (ch_mask != '0)) begin
            mask_q    <= ch_mask;
            ch_sel    <= CH_W'(first_ch);
            samp_cnt  <= SC_W'(SAMPLE_CYCLES);
            sample_en <= 1'b1;
            busy      <= 1'b1;
            state     <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (samp_cnt == SC_W'(1)) begin
            sample_en <= 1'b0;
            state     <= CONVERT;
          end else begin
            samp_cnt <= samp_cnt - SC_W'(1);
          end
        end
        CONVERT: begin
          if (eng_done) begin
            if (more_reps) begin
              samp_cnt  <= SC_W'(SAMPLE_CYCLES);
              sample_en <= 1'b1;
              state     <= SAMPLE;
            end else begin
              state <= STORE;
            end
          end
        end
        STORE: begin
          if (store_ok) begin
            result       <= store_code;
            result_ch    <= ch_sel;
            result_valid <= 1'b1;
            if (nxt_ch < 5'(NUM_CH)) begin
              ch_sel    <= CH_W'(nxt_ch);
              samp_cnt  <= SC_W'(SAMPLE_CYCLES);
              sample_en <= 1'b1;
              state     <= SAMPLE;
            end else if (cont && (ch_mask != '0)) begin
              mask_q    <= ch_mask;
              ch_sel    <= CH_W'(first_ch);
              samp_cnt  <= SC_W'(SAMPLE_CYCLES);
              sample_en <= 1'b1;
              state     <= SAMPLE;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_scan_ctrl.sv
// Directed bench for sar_scan_ctrl at default parameters; a comparator model
// resolves dac_code against a per-channel input voltage table.
module tb_sar_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, cont, result_ready, cmp_in;
  logic [3:0] ch_mask;
  logic [7:0] dac_code, result;
  logic       sample_en, busy, result_valid;
  logic [1:0] ch_sel, result_ch;

  logic [7:0] vin [4];
  logic [7:0] vin_cur;
  int         n_checks = 0;
  int         n_err    = 0;
  int         sel_bad  = 0;
  logic       watch_sel = 1'b0;

  always #5 clk = ~clk;

  sar_scan_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cont         (cont),
    .ch_mask      (ch_mask),
    .cmp_in       (cmp_in),
    .dac_code     (dac_code),
    .sample_en    (sample_en),
    .ch_sel       (ch_sel),
    .busy         (busy),
    .result       (result),
    .result_ch    (result_ch),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

`ifdef SAR_AVG_EN
  int conv_k = 0;
  always @(posedge sample_en) conv_k++;
`endif

  always_comb begin
    vin_cur = vin[ch_sel];
`ifdef SAR_AVG_EN
    vin_cur = 8'h10 + 8'(conv_k - 1);
`endif
    cmp_in = (dac_code <= vin_cur);
  end

  always @(negedge clk)
    if (watch_sel && busy && (ch_sel == 2'd0 || ch_sel == 2'd2)) sel_bad++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the edge that samples start.
  task automatic start_scan(input logic [3:0] m);
    ch_mask = m;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_next(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!result_valid && n < 200);
  endtask

  initial begin
    int n;
    int seen;
    logic [7:0] bounds [3];
    rst = 1'b1; start = 1'b0; cont = 1'b0; result_ready = 1'b1; ch_mask = 4'b0000;
    vin[0] = 8'h00; vin[1] = 8'h00; vin[2] = 8'h00; vin[3] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", result_valid, 0);
    check("rst_dac", dac_code, 0);
    check("rst_sample", sample_en, 0);
    rst = 1'b0;
    @(negedge clk);

`ifdef SAR_AVG_EN
    start_scan(4'b0001);
    wait_next(n);
    check("avg_result", result, 8'h11);
    check("avg_ch", result_ch, 0);
`else
    vin[0] = 8'hA5;
    start_scan(4'b0001);
    wait_next(n);
    check("single_latency", n, 12);
    check("single_result", result, 8'hA5);
    check("single_ch", result_ch, 0);
    check("single_busy_end", busy, 0);
    @(negedge clk);
    check("single_consumed", result_valid, 0);

    bounds[0] = 8'h00; bounds[1] = 8'hFF; bounds[2] = 8'h80;
    for (int i = 0; i < 3; i++) begin
      vin[0] = bounds[i];
      start_scan(4'b0001);
      wait_next(n);
      check("bound_result", result, {24'd0, bounds[i]});
      @(negedge clk);
    end

    vin[1] = 8'h3C; vin[3] = 8'hC3; vin[0] = 8'h11; vin[2] = 8'h22;
    watch_sel = 1'b1;
    start_scan(4'b1010);
    wait_next(n);
    check("sparse_ch_a", result_ch, 1);
    check("sparse_res_a", result, 8'h3C);
    wait_next(n);
    check("sparse_ch_b", result_ch, 3);
    check("sparse_res_b", result, 8'hC3);
    check("sparse_gap", n, 12);
    @(negedge clk);
    watch_sel = 1'b0;
    check("sparse_sel_skip", sel_bad, 0);

    vin[0] = 8'h5A; vin[1] = 8'h96;
    result_ready = 1'b0;
    start_scan(4'b0011);
    wait_next(n);
    check("bp_first_ch", result_ch, 0);
    check("bp_first_res", result, 8'h5A);
    repeat (20) @(negedge clk);
    check("bp_hold_res", result, 8'h5A);
    check("bp_hold_valid", result_valid, 1);
    check("bp_stall_busy", busy, 1);
    check("bp_dac_frozen", dac_code, 8'h96);
    repeat (5) @(negedge clk);
    check("bp_dac_frozen2", dac_code, 8'h96);
    result_ready = 1'b1;
    @(negedge clk);
    check("bp_second_res", result, 8'h96);
    check("bp_second_ch", result_ch, 1);
    check("bp_second_valid", result_valid, 1);
    check("bp_end_busy", busy, 0);
    @(negedge clk);
    check("bp_drained", result_valid, 0);

    vin[0] = 8'h33;
    cont = 1'b1;
    start_scan(4'b0001);
    wait_next(n);
    check("cont_lat1", n, 12);
    wait_next(n);
    check("cont_gap", n, 12);
    check("cont_res", result, 8'h33);
    check("cont_busy", busy, 1);
    cont = 1'b0;
    wait_next(n);
    check("cont_last_gap", n, 12);
    check("cont_end_busy", busy, 0);
    repeat (15) @(negedge clk);
    check("cont_stopped", result_valid, 0);

    vin[0] = 8'h77;
    start_scan(4'b0001);
    repeat (6) @(negedge clk);
    check("rst_mid_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("rstmid_dac", dac_code, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_result", result, 0);
    check("rstmid_sample", sample_en, 0);
    check("rstmid_ch_sel", ch_sel, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (result_valid) seen++;
    end
    check("rstmid_no_result", seen, 0);

    start_scan(4'b0000);
    repeat (3) @(negedge clk);
    check("mask0_busy", busy, 0);
    check("mask0_sample", sample_en, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/sar_scan_ctrl.md
Name: sar_scan_ctrl

Overview:
Parametrised successor to the single-channel 8-bit SAR controller. It runs successive-approximation conversions of WIDTH bits over up to NUM_CH multiplexed analog channels. It drives the DAC trial code, the sample switch and the mux select, and reads a single comparator. Each result leaves through a one-deep valid/ready output register tagged with its channel. It sits between the TinyTapeout top wrapper (pins) and the analog front end.

Parameters:
WIDTH, 8, conversion resolution in bits (2..16)
NUM_CH, 4, number of analog channels (1..16)
SAMPLE_CYCLES, 2, cycles sample_en is held high before the bit trials (>=1)
AVG_LOG2, 2, log2 of the conversions averaged per channel (used only with SAR_AVG_EN)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse; starts a scan when IDLE, ignored otherwise
cont  in  1  continuous mode; sampled at each scan end
ch_mask  in  NUM_CH  enabled channels; latched at start
cmp_in  in  1  comparator; 1 = Vin >= DAC(dac_code), keep trial bit
dac_code  out  WIDTH  DAC trial code
sample_en  out  1  sample/hold switch closed
ch_sel  out  CH_W  mux select, CH_W = max(1, clog2(NUM_CH))
busy  out  1  high in any state other than IDLE
result  out  WIDTH  converted code
result_ch  out  CH_W  channel of result
result_valid  out  1  result register full
result_ready  in  1  consumer accepts result when valid&&ready

Behaviour:
- Reset: all outputs 0; state IDLE; latched mask 0; output register empty.
- States: IDLE -> SAMPLE -> CONVERT -> STORE -> (SAMPLE of next channel | IDLE).
- IDLE: on start with ch_mask!=0, latch the mask, select the lowest set channel, go to SAMPLE. start with ch_mask==0 is ignored and no flag is raised.
- SAMPLE: sample_en=1 for exactly SAMPLE_CYCLES cycles; dac_code=0; ch_sel stable.
- CONVERT: WIDTH cycles, MSB first. At the first cycle, dac_code = 1<<(WIDTH-1). At each edge, cmp_in is registered into the current bit (1 keeps it, 0 clears it) and the next lower bit is set. After the LSB decision, dac_code holds the final code.
- STORE: if the output register is empty, or result_ready=1 this cycle, load result/result_ch, set result_valid, and advance. Otherwise stall in STORE, holding the code; no data is lost.
- Advance: go to the next higher set bit of the latched mask. After the last channel, if cont=1, re-latch ch_mask and restart from its lowest set bit. A re-latched mask of 0 goes to IDLE. If cont=0, go to IDLE.
- Latency: start edge to result_valid = 1+SAMPLE_CYCLES+WIDTH+1 cycles (12 at defaults), with an empty output register.
- result_valid clears on valid&&ready unless reloaded in the same cycle (reload wins).
- start while busy is ignored. Changes to ch_mask mid-scan have no effect until the next latch.
- Async rst mid-conversion returns to IDLE immediately; a partial code is never emitted.
- NUM_CH=1: ch_sel/result_ch tied to 0.

Optional Feature:
SAR_AVG_EN
- With it: each channel is converted 2^AVG_LOG2 consecutive times (SAMPLE+CONVERT repeated), into a WIDTH+AVG_LOG2 accumulator. STORE emits sum>>AVG_LOG2 (truncation). Latency is multiplied accordingly.
- Without it: a single conversion per channel; AVG_LOG2 is ignored and the accumulator is not built.

Decomposition:
- Package sar_pkg: state enum (IDLE, SAMPLE, CONVERT, STORE), the CH_W width function, and a lowest-set-bit-at-or-above-index function for mask scanning.
- Sub-module sar_bit_engine: start/done single-conversion core (trial register, bit counter, dac_code). sar_scan_ctrl owns sequencing, averaging and the output register.

Test Plan:
- Single-channel check: defaults; the bench compares dac_code<=vin for cmp_in; ch_mask=4'b0001, vin=0xA5, start pulse, result_ready=1. Required: result=0xA5, result_ch=0, result_valid exactly 12 cycles after start, then busy=0.
- Code boundaries: vin=0x00 -> result 0x00; vin=0xFF -> result 0xFF; vin=0x80 -> result 0x80.
- Sparse scan: ch_mask=4'b1010, vins {ch1=0x3C, ch3=0xC3}. Required: results (1,0x3C) then (3,0xC3) in that order; ch_sel never equals 0 or 2.
- Backpressure: result_ready=0 during a 2-channel scan. Required: the first result is held; the controller stalls in STORE with busy=1 and dac_code frozen. Raising ready releases both results in order, with nothing lost.
- Mode and reset: cont=1, mask=4'b0001 -> back-to-back results every 12 cycles; dropping cont ends after the current scan. rst asserted mid-CONVERT -> all outputs 0 at once and no result emitted. start with mask=0 -> busy stays 0.
- SAR_AVG_EN, AVG_LOG2=2: a comparator model giving codes {0x10,0x11,0x12,0x13} must produce result 0x11.
